// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants and the iteration controller state type
//
// Contents:
//   CORDIC_WIDTH    data width of X/Y/Z (Q3.29 two's complement)
//   CORDIC_FRAC     fractional bits of the fixed-point format
//   CORDIC_ITER_W   width of the stage iteration_number input
//   CORDIC_MAX_ITER largest iteration count the stage's shift/atan table supports
//   cordic_state_e  controller FSM states
package cordic_pkg;

    localparam int CORDIC_WIDTH    = 32;
    localparam int CORDIC_FRAC     = 29;
    localparam int CORDIC_ITER_W   = 5;
    localparam int CORDIC_MAX_ITER = 21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } cordic_state_e;

endpackage

// File: rtl/cordic_iter_ctrl_if.sv
// rtl/cordic_iter_ctrl_if.sv - operand-in / result-out handshake bundle of the CORDIC iteration controller
//
// Signals:
//   in_valid, in_ready         operand handshake
//   x_init, y_init, z_init     operand set (WIDTH bits each)
//   out_valid, out_ready       result handshake
//   x_res, y_res, z_res        result vector (WIDTH bits each)
// Modports:
//   master  upstream/downstream side (offers operands, accepts results)
//   slave   the controller
interface cordic_iter_ctrl_if #(
    parameter int WIDTH = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x_init;
    logic [WIDTH-1:0] y_init;
    logic [WIDTH-1:0] z_init;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] x_res;
    logic [WIDTH-1:0] y_res;
    logic [WIDTH-1:0] z_res;

    modport master (
        output in_valid, x_init, y_init, z_init, out_ready,
        input  in_ready, out_valid, x_res, y_res, z_res
    );

    modport slave (
        input  in_valid, x_init, y_init, z_init, out_ready,
        output in_ready, out_valid, x_res, y_res, z_res
    );

endinterface

// File: rtl/cordic_iter_ctrl.sv
// rtl/cordic_iter_ctrl.sv - iteration sequencer wrapped around a free-running single-stage CORDIC datapath
//
// Ports:
//   clk, rst_n                  rising-edge clock (shared with the stage), async active-low reset
//   bus (slave)                 operand in_valid/in_ready + x/y/z_init, result out_valid/out_ready + x/y/z_res
//   stg_x_in/stg_y_in/stg_z_in  vector fed to the stage (operands on pass 0, stage feedback afterwards)
//   stg_iter                    iteration_number driven to the stage
//   stg_x_out/..._out           registered vector returned by the stage
//   busy                        an operation is iterating or being captured
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int WIDTH    = CORDIC_WIDTH,
    parameter int NUM_ITER = 16,
    parameter int ITER_W   = CORDIC_ITER_W
) (
    input  logic              clk,
    input  logic              rst_n,
    cordic_iter_ctrl_if.slave bus,
    output logic [WIDTH-1:0]  stg_x_in,
    output logic [WIDTH-1:0]  stg_y_in,
    output logic [WIDTH-1:0]  stg_z_in,
    output logic [ITER_W-1:0] stg_iter,
    input  logic [WIDTH-1:0]  stg_x_out,
    input  logic [WIDTH-1:0]  stg_y_out,
    input  logic [WIDTH-1:0]  stg_z_out,
    output logic              busy
);

    // The stage's angle table only covers CORDIC_MAX_ITER entries, and the
    // counter must be able to hold the last iteration index.
    generate
        if (NUM_ITER < 1 || NUM_ITER > CORDIC_MAX_ITER) begin : g_bad_num_iter
            $error("cordic_iter_ctrl: NUM_ITER must be in 1..%0d", CORDIC_MAX_ITER);
        end
        if ((NUM_ITER - 1) >= (1 << ITER_W)) begin : g_bad_iter_w
            $error("cordic_iter_ctrl: ITER_W too narrow for NUM_ITER");
        end
        if (WIDTH < CORDIC_FRAC + 3) begin : g_bad_width
            $error("cordic_iter_ctrl: WIDTH cannot hold the Q3.%0d format", CORDIC_FRAC);
        end
    endgenerate

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_ITER - 1);

    cordic_state_e     state_q;
    cordic_state_e     state_d;
    logic [ITER_W-1:0] iter_q;
    logic [WIDTH-1:0]  op_x_q, op_y_q, op_z_q;
    logic [WIDTH-1:0]  res_x_q, res_y_q, res_z_q;
    logic              last_iter;
    logic              use_feedback;

    assign last_iter = (iter_q == LAST_ITER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        stg_iter      = '0;
        use_feedback  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                stg_iter = iter_q;
                // Pass 0 consumes the loaded operands; every later pass
                // recirculates the stage's own registered output.
                use_feedback = (iter_q != '0);
                if (last_iter) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                busy         = 1'b1;
                use_feedback = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stg_x_in = use_feedback ? stg_x_out : op_x_q;
    assign stg_y_in = use_feedback ? stg_y_out : op_y_q;
    assign stg_z_in = use_feedback ? stg_z_out : op_z_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_q  <= '0;
            op_x_q  <= '0;
            op_y_q  <= '0;
            op_z_q  <= '0;
            res_x_q <= '0;
            res_y_q <= '0;
            res_z_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_x_q <= bus.x_init;
                        op_y_q <= bus.y_init;
                        op_z_q <= bus.z_init;
                        iter_q <= '0;
                    end
                end
                RUN: begin
                    iter_q <= last_iter ? '0 : iter_q + 1'b1;
                end
                CAPT: begin
                    // The stage now holds the result of the final pass.
                    res_x_q <= stg_x_out;
                    res_y_q <= stg_y_out;
                    res_z_q <= stg_z_out;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.x_res = res_x_q;
    assign bus.y_res = res_y_q;
    assign bus.z_res = res_z_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb/tb_cordic_iter_ctrl.sv - self-checking bench for cordic_iter_ctrl with an add-one stub stage
module tb_cordic_iter_ctrl;
    import cordic_pkg::*;

    localparam int W  = 32;
    localparam int NA = 16;
    localparam int NB = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // DUT A: NUM_ITER = 16
    cordic_iter_ctrl_if #(.WIDTH(W)) ifa ();
    logic [W-1:0] xa_in, ya_in, za_in, xa_out, ya_out, za_out;
    logic [4:0]   itera;
    logic         busy_a;

    cordic_iter_ctrl #(.WIDTH(W), .NUM_ITER(NA), .ITER_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa),
        .stg_x_in(xa_in), .stg_y_in(ya_in), .stg_z_in(za_in), .stg_iter(itera),
        .stg_x_out(xa_out), .stg_y_out(ya_out), .stg_z_out(za_out), .busy(busy_a)
    );

    // DUT B: NUM_ITER = 1
    cordic_iter_ctrl_if #(.WIDTH(W)) ifb ();
    logic [W-1:0] xb_in, yb_in, zb_in, xb_out, yb_out, zb_out;
    logic [4:0]   iterb;
    logic         busy_b;

    cordic_iter_ctrl #(.WIDTH(W), .NUM_ITER(NB), .ITER_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb),
        .stg_x_in(xb_in), .stg_y_in(yb_in), .stg_z_in(zb_in), .stg_iter(iterb),
        .stg_x_out(xb_out), .stg_y_out(yb_out), .stg_z_out(zb_out), .busy(busy_b)
    );

    // Stub stages: each pass adds one to every field; iteration numbers are traced while busy.
    int trace_a[$];
    int trace_b[$];
    always @(posedge clk) begin
        if (busy_a === 1'b1) trace_a.push_back(int'(itera));
        if (busy_b === 1'b1) trace_b.push_back(int'(iterb));
        xa_out <= xa_in + 1; ya_out <= ya_in + 1; za_out <= za_in + 1;
        xb_out <= xb_in + 1; yb_out <= yb_in + 1; zb_out <= zb_in + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic run_a(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                         output int lat);
        @(negedge clk);
        ifa.x_init = x; ifa.y_init = y; ifa.z_init = z; ifa.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifa.in_valid = 1'b0;
        lat = 0;
        while (ifa.out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
        ifa.x_init = '0; ifa.y_init = '0; ifa.z_init = '0;
        ifb.in_valid = 1'b0; ifb.out_ready = 1'b0;
        ifb.x_init = '0; ifb.y_init = '0; ifb.z_init = '0;
        repeat (3) @(negedge clk);
        vectors++; if (ifa.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", ifa.out_valid); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_a); end
        vectors++; if (ifa.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", ifa.in_ready); end
        vectors++; if (itera !== 5'd0) begin miscompares++; $display("FAIL reset_stg_iter got %0d want 0", itera); end
        vectors++; if (ifa.x_res !== '0) begin miscompares++; $display("FAIL reset_x_res got %h want 0", ifa.x_res); end
        vectors++; if (ifa.y_res !== '0) begin miscompares++; $display("FAIL reset_y_res got %h want 0", ifa.y_res); end
        vectors++; if (ifa.z_res !== '0) begin miscompares++; $display("FAIL reset_z_res got %h want 0", ifa.z_res); end
        vectors++; if (ifb.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_b_in_ready got %b want 1", ifb.in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        trace_a.delete();
        run_a(32'h2000_0000, 32'h0, 32'h0400_0000, lat);
        vectors++; if (lat !== NA + 1) begin miscompares++; $display("FAIL basic_latency got %0d want %0d", lat, NA + 1); end
        vectors++; if (ifa.x_res !== 32'h2000_0010) begin miscompares++; $display("FAIL basic_x_res got %h want 20000010", ifa.x_res); end
        vectors++; if (ifa.y_res !== 32'h0000_0010) begin miscompares++; $display("FAIL basic_y_res got %h want 00000010", ifa.y_res); end
        vectors++; if (ifa.z_res !== 32'h0400_0010) begin miscompares++; $display("FAIL basic_z_res got %h want 04000010", ifa.z_res); end
        // Busy spans NA RUN cycles stepping 0..NA-1, then one CAPT cycle at 0.
        vectors++; if (trace_a.size() !== NA + 1) begin miscompares++; $display("FAIL basic_trace_len got %0d want %0d", trace_a.size(), NA + 1); end
        for (int i = 0; i < trace_a.size() && i <= NA; i++) begin
            vectors++;
            if (trace_a[i] !== ((i < NA) ? i : 0)) begin
                miscompares++; $display("FAIL basic_stg_iter[%0d] got %0d want %0d", i, trace_a[i], (i < NA) ? i : 0);
            end
        end
    endtask

    task automatic test_backpressure();
        ifa.out_ready = 1'b0;
        ifa.in_valid = 1'b1;
        ifa.x_init = 32'hDEAD_BEEF; ifa.y_init = 32'h1234_5678; ifa.z_init = 32'h0BAD_F00D;
        repeat (10) begin
            @(negedge clk);
            vectors++; if (ifa.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid got %b want 1", ifa.out_valid); end
            vectors++; if (ifa.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got %b want 0", ifa.in_ready); end
            vectors++; if (ifa.x_res !== 32'h2000_0010) begin miscompares++; $display("FAIL bp_x_res got %h want 20000010", ifa.x_res); end
            vectors++; if (ifa.z_res !== 32'h0400_0010) begin miscompares++; $display("FAIL bp_z_res got %h want 04000010", ifa.z_res); end
        end
        ifa.out_ready = 1'b1;
        @(negedge clk);
        vectors++; if (ifa.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_handoff_valid got %b want 0", ifa.out_valid); end
        vectors++; if (ifa.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_handoff_ready got %b want 1", ifa.in_ready); end
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
        @(negedge clk);
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL bp_ignored_in_valid busy got %b want 0", busy_a); end
    endtask

    // Scoreboard: every accepted operand set must come back as operand+NA, in order,
    // with at most one operation in flight.
    task automatic test_stream(input int n, input bit rnd);
        logic [W-1:0] tx [2];
        logic [W-1:0] ty [2];
        logic [W-1:0] tz [2];
        logic [W-1:0] qx[$], qy[$], qz[$];
        logic [W-1:0] nx, ny, nz;
        int sent = 0, got = 0, cyc = 0;
        tx[0] = 1;   ty[0] = 2;   tz[0] = 3;
        tx[1] = 100; ty[1] = 200; tz[1] = 300;
        nx = rnd ? $urandom : tx[0];
        ny = rnd ? $urandom : ty[0];
        nz = rnd ? $urandom : tz[0];
        while (got < n && cyc < n * 60) begin
            @(negedge clk);
            cyc++;
            ifa.x_init = nx; ifa.y_init = ny; ifa.z_init = nz;
            ifa.in_valid  = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            ifa.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ifa.out_valid === 1'b1) begin
                if (qx.size() == 0) begin
                    vectors++; miscompares++; $display("FAIL stream_unexpected_result x got %h want none", ifa.x_res);
                end else begin
                    vectors++; if (ifa.x_res !== qx[0]) begin miscompares++; $display("FAIL stream_x_res[%0d] got %h want %h", got, ifa.x_res, qx[0]); end
                    vectors++; if (ifa.y_res !== qy[0]) begin miscompares++; $display("FAIL stream_y_res[%0d] got %h want %h", got, ifa.y_res, qy[0]); end
                    vectors++; if (ifa.z_res !== qz[0]) begin miscompares++; $display("FAIL stream_z_res[%0d] got %h want %h", got, ifa.z_res, qz[0]); end
                    if (ifa.out_ready) begin
                        void'(qx.pop_front()); void'(qy.pop_front()); void'(qz.pop_front());
                        got++;
                    end
                end
            end
            if (ifa.in_valid && ifa.in_ready === 1'b1) begin
                qx.push_back(nx + NA); qy.push_back(ny + NA); qz.push_back(nz + NA);
                sent++;
                vectors++; if (qx.size() > 1) begin miscompares++; $display("FAIL stream_overlap in_flight got %0d want 1", qx.size()); end
                nx = rnd ? $urandom : tx[sent % 2];
                ny = rnd ? $urandom : ty[sent % 2];
                nz = rnd ? $urandom : tz[sent % 2];
            end
        end
        vectors++; if (got !== n) begin miscompares++; $display("FAIL stream_count got %0d want %0d", got, n); end
        @(negedge clk);
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int k = 0;
        int lat;
        bit seen_valid = 1'b0;
        @(negedge clk);
        ifa.x_init = 32'h55; ifa.y_init = 32'h66; ifa.z_init = 32'h77; ifa.in_valid = 1'b1;
        @(negedge clk);
        ifa.in_valid = 1'b0;
        while (itera !== 5'd7 && k < 30) begin @(negedge clk); k++; end
        vectors++; if (itera !== 5'd7) begin miscompares++; $display("FAIL midrst_reach_iter7 got %0d want 7", itera); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy_a); end
        vectors++; if (ifa.in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready got %b want 1", ifa.in_ready); end
        vectors++; if (itera !== 5'd0) begin miscompares++; $display("FAIL midrst_stg_iter got %0d want 0", itera); end
        vectors++; if (ifa.x_res !== '0) begin miscompares++; $display("FAIL midrst_x_res got %h want 0", ifa.x_res); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (ifa.out_valid !== 1'b0) seen_valid = 1'b1;
        end
        vectors++; if (seen_valid) begin miscompares++; $display("FAIL midrst_out_valid got 1 want 0"); end
        run_a(32'd10, 32'd20, 32'd30, lat);
        vectors++; if (lat !== NA + 1) begin miscompares++; $display("FAIL midrst_latency got %0d want %0d", lat, NA + 1); end
        vectors++; if (ifa.x_res !== 32'd26) begin miscompares++; $display("FAIL midrst_x_res_after got %0d want 26", ifa.x_res); end
        vectors++; if (ifa.y_res !== 32'd36) begin miscompares++; $display("FAIL midrst_y_res_after got %0d want 36", ifa.y_res); end
        vectors++; if (ifa.z_res !== 32'd46) begin miscompares++; $display("FAIL midrst_z_res_after got %0d want 46", ifa.z_res); end
        ifa.out_ready = 1'b1;
        @(negedge clk);
        ifa.out_ready = 1'b0;
    endtask

    task automatic test_num_iter_one();
        int lat = 0;
        trace_b.delete();
        @(negedge clk);
        ifb.x_init = 32'd5; ifb.y_init = 32'd7; ifb.z_init = 32'd9; ifb.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifb.in_valid = 1'b0;
        while (ifb.out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        vectors++; if (lat !== NB + 1) begin miscompares++; $display("FAIL n1_latency got %0d want %0d", lat, NB + 1); end
        vectors++; if (ifb.x_res !== 32'd6) begin miscompares++; $display("FAIL n1_x_res got %0d want 6", ifb.x_res); end
        vectors++; if (ifb.y_res !== 32'd8) begin miscompares++; $display("FAIL n1_y_res got %0d want 8", ifb.y_res); end
        vectors++; if (ifb.z_res !== 32'd10) begin miscompares++; $display("FAIL n1_z_res got %0d want 10", ifb.z_res); end
        vectors++; if (trace_b.size() !== NB + 1) begin miscompares++; $display("FAIL n1_trace_len got %0d want %0d", trace_b.size(), NB + 1); end
        for (int i = 0; i < trace_b.size(); i++) begin
            vectors++;
            if (trace_b[i] !== 0) begin miscompares++; $display("FAIL n1_stg_iter[%0d] got %0d want 0", i, trace_b[i]); end
        end
        ifb.out_ready = 1'b1;
        @(negedge clk);
        ifb.out_ready = 1'b0;
        vectors++; if (ifb.in_ready !== 1'b1) begin miscompares++; $display("FAIL n1_handoff_ready got %b want 1", ifb.in_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stream(2, 1'b0);
        test_stream(20, 1'b1);
        test_reset_mid_run();
        test_num_iter_one();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
